// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// input_conditioner_pkg -- shared debounce timing and pin-polarity constants
// Revision: 1.0
// ============================================================================
package input_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;

  // KEY pins pull low when pressed
  localparam logic KEY_PRESSED = 1'b0;

`ifdef SIMULATION
  localparam int BUILD_DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES;
`else
  localparam int BUILD_DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES;
`endif

endpackage
`default_nettype wire

// File: rtl/input_conditioner_debounce_cell.sv
`default_nettype none
// ============================================================================
// debounce_cell -- 2-FF synchronizer plus stable-count debouncer for one bit
// Revision: 1.0
// ============================================================================
module debounce_cell #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Any cycle of agreement restarts the count, so only an unbroken run is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= RESET_VALUE;
      sync2  <= RESET_VALUE;
      stable <= RESET_VALUE;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        rise   <= sync2;
        fall   <= ~sync2;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign level = stable;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// input_conditioner -- synchronizes and debounces KEY/SW pins into clean levels
// Revision: 1.0
// ============================================================================
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SWITCHES    = 10,
  parameter int DEBOUNCE_CYCLES = BUILD_DEBOUNCE_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_KEYS-1:0]     key_raw,
  input  logic [NUM_SWITCHES-1:0] switch_raw,
  output logic [NUM_KEYS-1:0]     key_level,
  output logic [NUM_KEYS-1:0]     key_press,
  output logic [NUM_KEYS-1:0]     key_release,
  output logic [NUM_SWITCHES-1:0] switch_level,
  output logic                    switch_change
);

  logic [NUM_KEYS-1:0]     key_stable;
  logic [NUM_KEYS-1:0]     key_rise;
  logic [NUM_KEYS-1:0]     key_fall;
  logic [NUM_SWITCHES-1:0] switch_rise;
  logic [NUM_SWITCHES-1:0] switch_fall;

  // Key cells idle at the released pin level so nothing strobes out of reset
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (~KEY_PRESSED)
    ) u_cell (
      .clock   (clock),
      .reset_n (reset_n),
      .in_raw  (key_raw[i]),
      .level   (key_stable[i]),
      .rise    (key_rise[i]),
      .fall    (key_fall[i])
    );
  end

  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_switch
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (1'b0)
    ) u_cell (
      .clock   (clock),
      .reset_n (reset_n),
      .in_raw  (switch_raw[i]),
      .level   (switch_level[i]),
      .rise    (switch_rise[i]),
      .fall    (switch_fall[i])
    );
  end

  assign key_level     = KEY_PRESSED ? key_stable : ~key_stable;
  assign key_press     = KEY_PRESSED ? key_rise   : key_fall;
  assign key_release   = KEY_PRESSED ? key_fall   : key_rise;
  assign switch_change = |(switch_rise | switch_fall);

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_input_conditioner -- directed self-checking bench, DEBOUNCE_CYCLES = 4
// Revision: 1.0
// ============================================================================
module tb_input_conditioner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] key_raw;
  logic [9:0] switch_raw;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [9:0] switch_level;
  logic       switch_change;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .NUM_KEYS        (4),
    .NUM_SWITCHES    (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .key_raw       (key_raw),
    .switch_raw    (switch_raw),
    .key_level     (key_level),
    .key_press     (key_press),
    .key_release   (key_release),
    .switch_level  (switch_level),
    .switch_change (switch_change)
  );

  always #10 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    key_raw    = 4'b1111;
    switch_raw = 10'd0;
    tick();
    tick();
    checks++;
    if ({key_level, key_press, key_release, switch_level, switch_change} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state: got kl=%b kp=%b kr=%b sl=%h sc=%b, want all 0",
               key_level, key_press, key_release, switch_level, switch_change);
    end
    reset_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if ({key_level, key_press, key_release, switch_level, switch_change} !== 23'd0) begin
        errors++;
        $display("FAIL post_reset_idle t=%0d: got kl=%b kp=%b kr=%b sl=%h sc=%b, want all 0",
                 t, key_level, key_press, key_release, switch_level, switch_change);
      end
    end
  endtask

  task automatic test_key_press_release();
    logic [3:0] exp_level, exp_press, exp_rel;
    key_raw = 4'b1110;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp_level = (t >= 6) ? 4'b0001 : 4'b0000;
      exp_press = (t == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (key_level !== exp_level || key_press !== exp_press || key_release !== 4'b0000) begin
        errors++;
        $display("FAIL key0_press t=%0d: got kl=%b kp=%b kr=%b, want kl=%b kp=%b kr=0000",
                 t, key_level, key_press, key_release, exp_level, exp_press);
      end
    end
    key_raw = 4'b1111;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_level = (t >= 6) ? 4'b0000 : 4'b0001;
      exp_rel   = (t == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (key_level !== exp_level || key_release !== exp_rel || key_press !== 4'b0000) begin
        errors++;
        $display("FAIL key0_release t=%0d: got kl=%b kp=%b kr=%b, want kl=%b kp=0000 kr=%b",
                 t, key_level, key_press, key_release, exp_level, exp_rel);
      end
    end
  endtask

  task automatic test_bounce();
    for (int t = 1; t <= 22; t++) begin
      // Two cycles low, two high, for 12 cycles, then released
      key_raw[1] = (t <= 12) ? (((t - 1) / 2) % 2 == 1) : 1'b1;
      tick();
      checks++;
      if (key_level !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
        errors++;
        $display("FAIL key1_bounce t=%0d: got kl=%b kp=%b kr=%b, want all 0000",
                 t, key_level, key_press, key_release);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_level, exp_press, exp_rel;
    key_raw = 4'b0011;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_level = (t >= 6) ? 4'b1100 : 4'b0000;
      exp_press = (t == 6) ? 4'b1100 : 4'b0000;
      checks++;
      if (key_level !== exp_level || key_press !== exp_press || key_release !== 4'b0000) begin
        errors++;
        $display("FAIL key23_press t=%0d: got kl=%b kp=%b kr=%b, want kl=%b kp=%b kr=0000",
                 t, key_level, key_press, key_release, exp_level, exp_press);
      end
    end
    key_raw = 4'b1111;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_level = (t >= 6) ? 4'b0000 : 4'b1100;
      exp_rel   = (t == 6) ? 4'b1100 : 4'b0000;
      checks++;
      if (key_level !== exp_level || key_release !== exp_rel || key_press !== 4'b0000) begin
        errors++;
        $display("FAIL key23_release t=%0d: got kl=%b kp=%b kr=%b, want kl=%b kp=0000 kr=%b",
                 t, key_level, key_press, key_release, exp_level, exp_rel);
      end
    end
  endtask

  task automatic test_switches();
    logic [9:0] exp_level;
    logic       exp_change;
    switch_raw = 10'h007;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_level  = (t >= 6) ? 10'h007 : 10'h000;
      exp_change = (t == 6);
      checks++;
      if (switch_level !== exp_level || switch_change !== exp_change) begin
        errors++;
        $display("FAIL switch_set t=%0d: got sl=%h sc=%b, want sl=%h sc=%b",
                 t, switch_level, switch_change, exp_level, exp_change);
      end
    end
    // Three-cycle glitch on SW[9] is one cycle short of acceptance
    for (int t = 1; t <= 12; t++) begin
      switch_raw = (t <= 3) ? 10'h207 : 10'h007;
      tick();
      checks++;
      if (switch_level !== 10'h007 || switch_change !== 1'b0) begin
        errors++;
        $display("FAIL switch_glitch t=%0d: got sl=%h sc=%b, want sl=007 sc=0",
                 t, switch_level, switch_change);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp_level, exp_press;
    logic [9:0] exp_sw;
    logic       exp_change;
    key_raw = 4'b0111;
    for (int t = 1; t <= 7; t++) tick();
    checks++;
    if (key_level !== 4'b1000 || switch_level !== 10'h007) begin
      errors++;
      $display("FAIL pre_reset_levels: got kl=%b sl=%h, want kl=1000 sl=007",
               key_level, switch_level);
    end
    key_raw = 4'b0110;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release, switch_level, switch_change} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset_clear: got kl=%b kp=%b kr=%b sl=%h sc=%b, want all 0",
               key_level, key_press, key_release, switch_level, switch_change);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_level  = (t >= 6) ? 4'b1001 : 4'b0000;
      exp_press  = (t == 6) ? 4'b1001 : 4'b0000;
      exp_sw     = (t >= 6) ? 10'h007 : 10'h000;
      exp_change = (t == 6);
      checks++;
      if (key_level !== exp_level || key_press !== exp_press || key_release !== 4'b0000 ||
          switch_level !== exp_sw || switch_change !== exp_change) begin
        errors++;
        $display("FAIL held_after_reset t=%0d: got kl=%b kp=%b kr=%b sl=%h sc=%b, want kl=%b kp=%b kr=0000 sl=%h sc=%b",
                 t, key_level, key_press, key_release, switch_level, switch_change,
                 exp_level, exp_press, exp_sw, exp_change);
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_press_release();
    test_bounce();
    test_simultaneous();
    test_switches();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
